// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, start/pause/lap/clear FSM,
// count-enable prescaler, lap display snapshot and 59:59 stop.

module stopwatch_ctrl_debounce #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge of the accepted level only; releases are silent.
    assign press = level & ~level_q;
endmodule

module stopwatch_ctrl #(
    parameter int PRESCALE = 50_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic [3:0] dig_1,
    input  logic [3:0] dig_2,
    input  logic [3:0] dig_3,
    input  logic [3:0] dig_4,
    output logic       tick_en,
    output logic       clr,
    output logic [3:0] disp_dig_1,
    output logic [3:0] disp_dig_2,
    output logic [3:0] disp_dig_3,
    output logic [3:0] disp_dig_4,
    output logic [2:0] state,
    output logic       done
);
    localparam int NUM_BTN = 3;
    localparam int PW      = $clog2(PRESCALE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               st;
    logic [PW-1:0]        pcnt;
    logic [NUM_BTN-1:0]   btn_raw;
    logic [NUM_BTN-1:0]   press;
    logic [3:0][3:0]      live;
    logic [3:0][3:0]      disp;
    logic                 go_clear, go_start, go_lap;
    logic                 wrap, at_max;

    assign btn_raw = {btn_lap, btn_clear, btn_start};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            stopwatch_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_raw[i]),
                .press (press[i])
            );
        end
    endgenerate

    // clear > start > lap; a lower-priority press in the same cycle is lost.
    assign go_clear = press[1];
    assign go_start = press[0] & ~press[1];
    assign go_lap   = press[2] & ~press[1] & ~press[0];

    assign live   = {dig_4, dig_3, dig_2, dig_1};
    assign wrap   = ((st == RUN) || (st == LAP)) && (pcnt == PW'(PRESCALE - 1));
    assign at_max = (dig_4 == 4'd5) && (dig_3 == 4'd9) && (dig_2 == 4'd5) && (dig_1 == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            pcnt    <= '0;
            tick_en <= 1'b0;
            clr     <= 1'b0;
            done    <= 1'b0;
            disp    <= '0;
        end else begin
            tick_en <= 1'b0;
            clr     <= 1'b0;
            if (st != LAP)
                disp <= live;
            case (st)
                IDLE: begin
                    pcnt <= '0;
                    if (go_clear)
                        clr <= 1'b1;
                    else if (go_start)
                        st <= RUN;
                end
                RUN, LAP: begin
                    if (wrap && at_max) begin
                        st   <= DONE;
                        done <= 1'b1;
                        pcnt <= '0;
                    end else if (go_start) begin
                        // Pausing freezes the prescaler so the partial second survives.
                        st   <= PAUSE;
                        disp <= live;
                    end else begin
                        pcnt    <= wrap ? '0 : pcnt + 1'b1;
                        tick_en <= wrap;
                        if (go_lap) begin
                            st   <= (st == RUN) ? LAP : RUN;
                            disp <= live;
                        end
                    end
                end
                PAUSE: begin
                    if (go_clear) begin
                        st   <= IDLE;
                        clr  <= 1'b1;
                        pcnt <= '0;
                    end else if (go_start) begin
                        st <= RUN;
                    end
                end
                DONE: begin
                    if (go_clear) begin
                        st   <= IDLE;
                        done <= 1'b0;
                        clr  <= 1'b1;
                        pcnt <= '0;
                    end
                end
                default: begin
                    st   <= IDLE;
                    done <= 1'b0;
                    pcnt <= '0;
                end
            endcase
        end
    end

    assign state      = st;
    assign disp_dig_1 = disp[0];
    assign disp_dig_2 = disp[1];
    assign disp_dig_3 = disp[2];
    assign disp_dig_4 = disp[3];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with PRESCALE=4, DEBOUNCE=3; expectations are
// queued with a target cycle and checked on the falling edge.

module tb_stopwatch_ctrl;
    localparam int P = 4;
    localparam int D = 3;
    localparam int K_ST = 0, K_TK = 1, K_CLR = 2, K_DONE = 3, K_DISP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0;
    logic       tick_en, clr, done;
    logic [3:0] disp_dig_1, disp_dig_2, disp_dig_3, disp_dig_4;
    logic [2:0] state;

    stopwatch_ctrl #(.PRESCALE(P), .DEBOUNCE(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .btn_lap    (btn_lap),
        .dig_1      (d1),
        .dig_2      (d2),
        .dig_3      (d3),
        .dig_4      (d4),
        .tick_en    (tick_en),
        .clr        (clr),
        .disp_dig_1 (disp_dig_1),
        .disp_dig_2 (disp_dig_2),
        .disp_dig_3 (disp_dig_3),
        .disp_dig_4 (disp_dig_4),
        .state      (state),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic       s, c, l;
        logic [2:0] st;
        logic       clr;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    function automatic logic [15:0] actual(input int k);
        case (k)
            K_ST:    return {13'd0, state};
            K_TK:    return {15'd0, tick_en};
            K_CLR:   return {15'd0, clr};
            K_DONE:  return {15'd0, done};
            default: return {disp_dig_4, disp_dig_3, disp_dig_2, disp_dig_1};
        endcase
    endfunction

    task automatic expa(input int c, input int k, input logic [15:0] v, input string nm);
        sb.push_back('{c, k, v, nm});
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_at(input int c, input logic s, input logic cl, input logic l);
        go_to(c);
        btn_start = s; btn_clear = cl; btn_lap = l;
        go_to(c + 5);
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    endtask

    // Scoreboard consumer: compare every entry whose cycle has arrived.
    initial forever begin
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_checks++;
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s @%0d: check missed, now cycle %0d", sb[i].name, sb[i].cyc, cyc);
                end else if (actual(sb[i].kind) !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s @%0d: got %h want %h", sb[i].name, sb[i].cyc,
                             actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[16];
    int   c;
    logic [2:0] prev;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0}; // lap ignored in IDLE
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1}; // clear in IDLE
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0}; // clear ignored in RUN
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b0}; // lap ignored in PAUSE
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0}; // clear ignored in LAP
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0}; // start in LAP pauses
        tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1}; // clear beats start
        tbl[13] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b0}; // start beats lap in RUN
        tbl[15] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1};

        expa(1, K_ST, 0, "rst_state");
        expa(1, K_TK, 0, "rst_tick");
        expa(1, K_CLR, 0, "rst_clr");
        expa(1, K_DONE, 0, "rst_done");
        expa(1, K_DISP, 0, "rst_disp");
        go_to(2);
        rst = 1'b0;

        // State-transition table: state changes 6 edges after the raw press.
        prev = 3'd0;
        for (int i = 0; i < 16; i++) begin
            c = 4 + 16 * i;
            expa(c + 5, K_ST, prev, $sformatf("tbl%0d_hold", i));
            expa(c + 6, K_ST, tbl[i].st, $sformatf("tbl%0d_state", i));
            expa(c + 6, K_CLR, tbl[i].clr, $sformatf("tbl%0d_clr", i));
            expa(c + 7, K_CLR, 0, $sformatf("tbl%0d_clr_off", i));
            press_at(c, tbl[i].s, tbl[i].c, tbl[i].l);
            prev = tbl[i].st;
        end

        // Start at 276, pause at 287 with 2 retained, resume at 298.
        expa(275, K_ST, 0, "run_pre");
        expa(276, K_ST, 1, "run_state");
        expa(276, K_TK, 0, "run_t0");
        expa(279, K_TK, 0, "run_t3");
        expa(280, K_TK, 1, "run_tick1");
        expa(281, K_TK, 0, "run_t5");
        expa(283, K_TK, 0, "run_t7");
        expa(284, K_TK, 1, "run_tick2");
        press_at(270, 1'b1, 1'b0, 1'b0);
        expa(286, K_ST, 1, "pause_pre");
        expa(287, K_ST, 2, "pause_state");
        for (int k = 287; k <= 297; k++) expa(k, K_TK, 0, "pause_notick");
        press_at(281, 1'b1, 1'b0, 1'b0);
        expa(298, K_ST, 1, "resume_state");
        expa(299, K_TK, 0, "resume_t1");
        expa(300, K_TK, 1, "resume_tick");
        expa(301, K_TK, 0, "resume_t3");
        expa(304, K_TK, 1, "resume_tick2");
        press_at(292, 1'b1, 1'b0, 1'b0);
        go_to(300);
        d1 = 4'd7;

        // Asynchronous reset in a tick cycle, then a quiet stretch.
        expa(308, K_ST, 0, "arst_state");
        expa(308, K_TK, 0, "arst_tick");
        expa(308, K_CLR, 0, "arst_clr");
        expa(308, K_DONE, 0, "arst_done");
        expa(308, K_DISP, 0, "arst_disp");
        go_to(308);
        #2 rst = 1'b1;
        go_to(310);
        rst = 1'b0;
        d1 = 4'd0;
        for (int k = 311; k <= 330; k++) begin
            expa(k, K_TK, 0, "post_rst_tick");
            expa(k, K_ST, 0, "post_rst_state");
        end

        // 2-cycle glitch is rejected; a held press lands 6 edges later.
        for (int k = 341; k <= 356; k++) expa(k, K_ST, 0, "glitch_state");
        go_to(340);
        btn_start = 1'b1;
        go_to(342);
        btn_start = 1'b0;
        expa(365, K_ST, 0, "deb_pre");
        expa(366, K_ST, 1, "deb_state");
        press_at(360, 1'b1, 1'b0, 1'b0);

        // Lap snapshot 0,3,1,0 while live digits advance.
        go_to(367);
        d1 = 4'd0; d2 = 4'd3; d3 = 4'd1; d4 = 4'd0;
        expa(370, K_TK, 1, "lap_pre_tick");
        expa(377, K_ST, 1, "lap_pre");
        expa(378, K_ST, 3, "lap_state");
        expa(378, K_DISP, 16'h0130, "lap_snap");
        expa(380, K_DISP, 16'h0130, "lap_hold1");
        expa(382, K_TK, 1, "lap_tick1");
        expa(383, K_TK, 0, "lap_t_off");
        expa(384, K_DISP, 16'h0130, "lap_hold2");
        expa(386, K_TK, 1, "lap_tick2");
        expa(388, K_ST, 3, "lap_state2");
        expa(388, K_DISP, 16'h0130, "lap_hold3");
        expa(390, K_DISP, 16'h0130, "lap_hold4");
        expa(391, K_ST, 1, "unlap_state");
        expa(391, K_DISP, 16'h0133, "unlap_live");
        expa(392, K_DISP, 16'h0133, "unlap_live2");
        expa(393, K_DISP, 16'h0134, "unlap_follow");
        press_at(372, 1'b0, 1'b0, 1'b1);
        go_to(379);
        d1 = 4'd1;
        go_to(383);
        d1 = 4'd2;
        press_at(385, 1'b0, 1'b0, 1'b1);
        d1 = 4'd3;
        go_to(392);
        d1 = 4'd4;

        // Clear ignored in RUN; clear+start in PAUSE clears once.
        expa(401, K_ST, 1, "runclr_pre");
        expa(402, K_ST, 1, "runclr_state");
        expa(402, K_CLR, 0, "runclr_clr");
        expa(403, K_CLR, 0, "runclr_clr2");
        press_at(396, 1'b0, 1'b1, 1'b0);
        expa(411, K_ST, 1, "p2_pre");
        expa(412, K_ST, 2, "p2_state");
        for (int k = 412; k <= 437; k++) expa(k, K_TK, 0, "idle_notick");
        press_at(406, 1'b1, 1'b0, 1'b0);
        expa(423, K_ST, 2, "pclr_pre");
        expa(423, K_CLR, 0, "pclr_clr_pre");
        expa(424, K_ST, 0, "pclr_state");
        expa(424, K_CLR, 1, "pclr_clr");
        expa(425, K_CLR, 0, "pclr_clr_off");
        expa(426, K_CLR, 0, "pclr_clr_off2");
        press_at(418, 1'b1, 1'b1, 1'b0);

        // Restart from a zeroed prescaler, then overflow with a start press.
        expa(437, K_ST, 0, "rs_pre");
        expa(438, K_ST, 1, "rs_state");
        expa(441, K_TK, 0, "rs_t3");
        expa(442, K_TK, 1, "rs_tick");
        expa(446, K_TK, 1, "rs_tick2");
        press_at(432, 1'b1, 1'b0, 1'b0);
        expa(449, K_ST, 1, "ovf_pre");
        expa(449, K_DONE, 0, "ovf_done_pre");
        expa(450, K_TK, 0, "ovf_tick");
        expa(450, K_ST, 4, "ovf_state");
        expa(450, K_DONE, 1, "ovf_done");
        for (int k = 451; k <= 475; k++) expa(k, K_TK, 0, "done_notick");
        go_to(444);
        btn_start = 1'b1;
        go_to(447);
        d1 = 4'd9; d2 = 4'd5; d3 = 4'd9; d4 = 4'd5;
        go_to(449);
        btn_start = 1'b0;
        expa(462, K_ST, 4, "done_start_ign");
        expa(462, K_DONE, 1, "done_start_done");
        press_at(456, 1'b1, 1'b0, 1'b0);
        expa(473, K_CLR, 0, "dclr_pre");
        expa(474, K_ST, 0, "dclr_state");
        expa(474, K_CLR, 1, "dclr_clr");
        expa(474, K_DONE, 0, "dclr_done");
        expa(475, K_CLR, 0, "dclr_clr_off");
        press_at(468, 1'b0, 1'b1, 1'b0);

        go_to(480);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
